bus_scheduler: RTL

Fixed-period bus slot scheduler for the shared RAM/IO bus. It runs directly upstream of the `cpu` bus-phase timing block. Once per CPU period it issues the one-cycle `cpu_grant_o` that starts the CPU's BE/Phi2 sequence. In the rest of the period it arbitrates bounded-length wishbone transactions between video fetch and the SPI bridge, so that every transaction drains before the next CPU slot begins.

---
 rtl/bus_scheduler_if.sv | 25 ++
 rtl/bus_scheduler.sv | 107 ++++++++++
 2 files changed

// File: rtl/bus_scheduler_if.sv
// Scheduler-to-requester bus bundle: CPU run/grant, video and SPI request/grant,
// wishbone done/timeout and the slot counter for debug capture.
interface bus_scheduler_if #(
   parameter int PERIOD = 64
);
   logic                      cpu_run_i;
   logic                      cpu_grant_o;
   logic                      video_req_i;
   logic                      video_gnt_o;
   logic                      spi_req_i;
   logic                      spi_gnt_o;
   logic                      wb_done_i;
   logic [$clog2(PERIOD)-1:0] slot_count_o;
   logic                      wb_timeout_o;

   modport master (
      input  cpu_run_i, video_req_i, spi_req_i, wb_done_i,
      output cpu_grant_o, video_gnt_o, spi_gnt_o, slot_count_o, wb_timeout_o
   );

   modport slave (
      output cpu_run_i, video_req_i, spi_req_i, wb_done_i,
      input  cpu_grant_o, video_gnt_o, spi_gnt_o, slot_count_o, wb_timeout_o
   );
endinterface

// File: rtl/bus_scheduler.sv
// Fixed-period slot scheduler: one CPU grant at count 0, then video/SPI wishbone grants one cycle after
// an in-window IDLE request; requests simply wait (no backpressure) while BUSY or outside the window.
module bus_scheduler #(
   parameter int PERIOD   = 64,
   parameter int CPU_SLOT = 14,
   parameter int WB_MAX   = 5
) (
   input  logic            sys_clock_i,
   input  logic            sys_reset_i,
   bus_scheduler_if.master bus
);
   localparam int CW = $clog2(PERIOD);
   localparam int BW = (WB_MAX > 1) ? $clog2(WB_MAX) : 1;

   localparam logic [CW-1:0] LAST      = CW'(PERIOD - 1);
   localparam logic [CW-1:0] WIN_LO    = CW'(CPU_SLOT);
   localparam logic [CW-1:0] WIN_HI    = CW'(PERIOD - WB_MAX);
   localparam logic [CW-1:0] STARVE_AT = CW'(PERIOD - WB_MAX + 1);
   localparam logic [BW-1:0] BUSY_LAST = BW'(WB_MAX - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_nxt;
   logic [BW-1:0]   busy_cnt_q;
   logic            run_q;
   logic            starved_q;
   logic            spi_got_q;
   logic            timeout_q;
   logic            vid_gnt_q, spi_gnt_q;
   logic            vid_gnt_d, spi_gnt_d;
   logic            in_win, done_ok, expire, can_grant;

   always_comb begin
      count_nxt = (count_q == LAST) ? '0 : count_q + 1'b1;
      // The window is judged on the count the grant pulse will actually appear in.
      in_win    = (count_nxt >= WIN_LO) && (count_nxt <= WIN_HI);
      done_ok   = (state_q == BUSY) && bus.wb_done_i;
      expire    = (state_q == BUSY) && (busy_cnt_q == BUSY_LAST);
      // The grant cycle itself never frees the bus: the requester's req is still stale there.
      can_grant = (state_q == IDLE) || ((done_ok || expire) && (busy_cnt_q != '0));
      spi_gnt_d = can_grant && in_win && bus.spi_req_i && (starved_q || !bus.video_req_i);
      vid_gnt_d = can_grant && in_win && bus.video_req_i && !spi_gnt_d;

      state_d = state_q;
      if (spi_gnt_d || vid_gnt_d) begin
         state_d = BUSY;
      end else if (done_ok || expire) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge sys_clock_i) begin
      if (sys_reset_i) begin
         state_q    <= IDLE;
         count_q    <= '0;
         busy_cnt_q <= '0;
         run_q      <= 1'b0;
         starved_q  <= 1'b0;
         spi_got_q  <= 1'b0;
         timeout_q  <= 1'b0;
         vid_gnt_q  <= 1'b0;
         spi_gnt_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_nxt;
         vid_gnt_q <= vid_gnt_d;
         spi_gnt_q <= spi_gnt_d;

         if (count_q == LAST) begin
            run_q <= bus.cpu_run_i;
         end

         if (spi_gnt_d || vid_gnt_d) begin
            busy_cnt_q <= '0;
         end else if (state_q == BUSY) begin
            busy_cnt_q <= busy_cnt_q + 1'b1;
         end

         if (expire && !bus.wb_done_i) begin
            timeout_q <= 1'b1;
         end

         // Starvation is judged just after the last possible grant cycle of the window.
         if (spi_gnt_d) begin
            starved_q <= 1'b0;
         end else if ((count_q == STARVE_AT) && bus.spi_req_i && !spi_got_q) begin
            starved_q <= 1'b1;
         end

         if (count_q == STARVE_AT) begin
            spi_got_q <= 1'b0;
         end else if (spi_gnt_d) begin
            spi_got_q <= 1'b1;
         end
      end
   end

   assign bus.cpu_grant_o  = run_q && (count_q == '0);
   assign bus.video_gnt_o  = vid_gnt_q;
   assign bus.spi_gnt_o    = spi_gnt_q;
   assign bus.slot_count_o = count_q;
   assign bus.wb_timeout_o = timeout_q;
endmodule
